// File: rtl/eth_pr_pkg.sv
// Shared types and constants for the packet-replay classification path.
package eth_pr_pkg;

  localparam int unsigned PORT_LSB = 16;
  localparam int unsigned SLOT_W   = 6;
  localparam int unsigned PORT_W   = 2;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [SLOT_W-1:0] slot;
  } tag_t;

  typedef enum logic {
    ST_IDLE,
    ST_INPKT
  } pkt_state_e;

  function automatic tag_t make_tag(input logic [PORT_W-1:0] port,
                                    input logic [SLOT_W-1:0] slot);
    tag_t t;
    t.port = port;
    t.slot = slot;
    return t;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// First-word-fall-through FIFO; wrap bit on each pointer distinguishes full from empty.
module tag_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign head_valid = !empty;

endmodule

// File: rtl/packet_tagger.sv
// Tags each replayed packet with {egress port, storage slot} after a fixed latency,
// buffering tags in a credit-protected FIFO so tagstream backpressure never drops one.
module packet_tagger
  import eth_pr_pkg::*;
#(
  parameter int unsigned LATENCY    = 7,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [5:0]  in_channel,
  output logic        in_ready,
  output logic [7:0]  tag_data,
  output logic        tag_valid,
  input  logic        tag_ready,
  output logic [7:0]  err_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $bits(tag_t);

  pkt_state_e          state_q, state_d;
  logic [PORT_W-1:0]   port_q, port_d;
  logic [7:0]          err_q, err_d;
  logic [CW-1:0]       credits_q, credits_d;
  logic [LATENCY-1:0]  pipe_v_q, pipe_v_d;
  tag_t                pipe_tag_q [LATENCY];
  tag_t                pipe_tag_d [LATENCY];

  logic              accept;
  logic              launch;
  tag_t              launch_tag;
  logic              err_inc;
  logic [PORT_W-1:0] sop_port;
  logic              pop;
  logic [TW-1:0]     fifo_head;
  logic              fifo_valid;
  logic              unused_data_bits;

  assign in_ready = !reset && (credits_q < CW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign sop_port = in_data[PORT_LSB +: PORT_W];

  assign unused_data_bits = ^{in_data[63:PORT_LSB+PORT_W], in_data[PORT_LSB-1:0]};

  // Packet tracking FSM and tag launch
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    launch     = 1'b0;
    launch_tag = '0;
    err_inc    = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_sop) begin
            port_d = sop_port;
            if (in_eop) begin
              launch     = 1'b1;
              launch_tag = make_tag(sop_port, in_channel);
            end else begin
              state_d = ST_INPKT;
            end
          end else begin
            err_inc = 1'b1;
            if (in_eop) begin
              launch     = 1'b1;
              launch_tag = make_tag('0, in_channel);
            end
          end
        end
        ST_INPKT: begin
          if (in_sop) begin
            // Restart: the abandoned packet never reaches eop, so it never launches a tag.
            err_inc = 1'b1;
            port_d  = sop_port;
            if (in_eop) begin
              launch     = 1'b1;
              launch_tag = make_tag(sop_port, in_channel);
              state_d    = ST_IDLE;
            end
          end else if (in_eop) begin
            launch     = 1'b1;
            launch_tag = make_tag(port_q, in_channel);
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // Fixed-latency pipe; advances every cycle since credits guarantee FIFO room.
  always_comb begin
    for (int unsigned i = 0; i < LATENCY; i++) begin
      pipe_tag_d[i] = pipe_tag_q[i];
    end
    pipe_v_d      = pipe_v_q;
    pipe_v_d[0]   = launch;
    pipe_tag_d[0] = launch_tag;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  assign pop = tag_valid && tag_ready;

  always_comb begin
    credits_d = credits_q;
    unique case ({launch, pop})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      port_q    <= '0;
      err_q     <= '0;
      credits_q <= '0;
      pipe_v_q  <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      err_q      <= err_d;
      credits_q  <= credits_d;
      pipe_v_q   <= pipe_v_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

  tag_fifo #(
    .WIDTH (TW),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (pipe_v_q[LATENCY-1]),
    .push_data  (pipe_tag_q[LATENCY-1]),
    .pop        (pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid)
  );

  // Registered state still holds pre-reset values during the reset cycle, so outputs are masked.
  assign tag_valid = !reset && fifo_valid;
  assign tag_data  = reset ? '0 : fifo_head;
  assign err_count = reset ? '0 : err_q;

endmodule

// File: tb/tb_packet_tagger.sv
// Directed and randomized checks of packet_tagger against a tag-queue reference model.
module tb_packet_tagger;

  localparam int LAT   = 7;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [5:0]  in_channel = '0;
  logic        in_ready;
  logic [7:0]  tag_data;
  logic        tag_valid;
  logic        tag_ready = 1'b1;
  logic [7:0]  err_count;

  packet_tagger #(
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_channel (in_channel),
    .in_ready   (in_ready),
    .tag_data   (tag_data),
    .tag_valid  (tag_valid),
    .tag_ready  (tag_ready),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  // Reference: every launched tag waits in exp_q until popped; it becomes visible
  // LAT edges after the accepting edge. Outstanding credits are simply exp_q.size().
  typedef struct {
    logic [7:0] tag;
    int         rdy;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] popped_q[$];
  int         now = 0;
  int         m_err = 0;
  bit         m_inpkt = 1'b0;
  logic [1:0] m_port = '0;
  bit         last_acc = 1'b0;
  bit         rand_rdy = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag, input int pending);
    checks++;
    failures++;
    $error("FAIL %s observed=%0d expected=0", tag, pending);
  endtask

  function automatic void launch_tag(input logic [1:0] port, input logic [5:0] ch);
    exp_t e;
    e.tag = {port, ch};
    e.rdy = now + LAT;
    exp_q.push_back(e);
  endfunction

  function automatic void model_beat(input bit sop, input bit eop,
                                     input logic [1:0] dport, input logic [5:0] ch);
    if (sop) begin
      if (m_inpkt && m_err < 255) m_err++;
      m_port = dport;
      if (eop) begin
        launch_tag(dport, ch);
        m_inpkt = 1'b0;
      end else begin
        m_inpkt = 1'b1;
      end
    end else if (m_inpkt) begin
      if (eop) begin
        launch_tag(m_port, ch);
        m_inpkt = 1'b0;
      end
    end else begin
      if (m_err < 255) m_err++;
      if (eop) launch_tag(2'b00, ch);
    end
  endfunction

  task automatic cycle();
    bit         ein, etv, acc, pop, rst, s_sop, s_eop;
    logic [7:0] etd;
    logic [1:0] s_port;
    logic [5:0] s_ch;
    if (rand_rdy) tag_ready = ($urandom_range(0, 3) != 0);
    @(negedge clock);
    rst = reset;
    ein = !rst && (exp_q.size() < DEPTH);
    etv = !rst && (exp_q.size() > 0) && (exp_q[0].rdy <= now);
    etd = etv ? exp_q[0].tag : 8'h00;
    chk("in_ready", in_ready, ein);
    chk("tag_valid", tag_valid, etv);
    chk("err_count", err_count, rst ? 0 : m_err);
    if (etv || rst) chk("tag_data", tag_data, etd);
    acc    = in_valid && ein;
    pop    = etv && tag_ready;
    s_sop  = in_sop;
    s_eop  = in_eop;
    s_port = in_data[17:16];
    s_ch   = in_channel;
    if (pop) popped_q.push_back(tag_data);
    @(posedge clock);
    now++;
    if (rst) begin
      exp_q.delete();
      m_inpkt = 1'b0;
      m_err   = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) model_beat(s_sop, s_eop, s_port, s_ch);
    end
    last_acc = acc;
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send_beat(input bit sop, input bit eop, input logic [1:0] port,
                           input logic [5:0] ch);
    logic [63:0] d;
    d          = {$urandom, $urandom};
    d[17:16]   = port;
    in_data    = d;
    in_sop     = sop;
    in_eop     = eop;
    in_channel = ch;
    in_valid   = 1'b1;
    last_acc   = 1'b0;
    for (int n = 0; n < 200; n++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) timeout_fail("accept_timeout", 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && exp_q.size() > 0; n++) cycle();
    if (exp_q.size() > 0) timeout_fail("drain_timeout", exp_q.size());
    cycle();
  endtask

  initial begin
    logic [7:0] bp_exp[10];
    logic [1:0] p;

    // Reset state
    tag_ready = 1'b1;
    reset     = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    #3;
    chk("post_reset_in_ready", in_ready, 1);
    idle(2);

    // Basic 4-beat packet, slot 5, port 2'b10
    popped_q.delete();
    send_beat(1'b1, 1'b0, 2'b10, 6'd5);
    send_beat(1'b0, 1'b0, 2'b01, 6'd5);
    send_beat(1'b0, 1'b0, 2'b11, 6'd5);
    send_beat(1'b0, 1'b1, 2'b00, 6'd5);
    idle(LAT - 1);
    #3;
    chk("basic_not_early", tag_valid, 0);
    idle(1);
    #3;
    chk("basic_valid", tag_valid, 1);
    chk("basic_data", tag_data, 8'h85);
    drain();
    chk("basic_count", popped_q.size(), 1);
    if (popped_q.size() > 0) chk("basic_tag", popped_q[0], 8'h85);
    chk("basic_err", err_count, 0);

    // Back-to-back single-beat packets
    popped_q.delete();
    for (int i = 0; i < 16; i++) begin
      logic [5:0] s;
      s = 6'(i);
      send_beat(1'b1, 1'b1, s[1:0], s);
    end
    drain();
    chk("b2b_count", popped_q.size(), 16);
    for (int i = 0; i < 16 && i < popped_q.size(); i++) begin
      logic [5:0] s;
      s = 6'(i);
      chk("b2b_tag", popped_q[i], {s[1:0], s});
    end

    // Backpressure: 8 packets fill all credits
    popped_q.delete();
    tag_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      p         = 2'($urandom_range(0, 3));
      bp_exp[i] = {p, 6'(20 + i)};
    end
    for (int i = 0; i < 8; i++) send_beat(1'b1, 1'b1, bp_exp[i][7:6], bp_exp[i][5:0]);
    #3;
    chk("bp_in_ready_low", in_ready, 0);
    idle(LAT);
    #3;
    chk("bp_tag_valid", tag_valid, 1);
    chk("bp_head", tag_data, bp_exp[0]);
    chk("bp_still_blocked", in_ready, 0);
    idle(3);
    #3;
    chk("bp_head_stable", tag_data, bp_exp[0]);
    tag_ready = 1'b1;
    for (int i = 8; i < 10; i++) send_beat(1'b1, 1'b1, bp_exp[i][7:6], bp_exp[i][5:0]);
    drain();
    chk("bp_count", popped_q.size(), 10);
    for (int i = 0; i < 10 && i < popped_q.size(); i++) chk("bp_tag", popped_q[i], bp_exp[i]);

    // Protocol errors
    popped_q.delete();
    send_beat(1'b1, 1'b0, 2'b01, 6'd9);
    send_beat(1'b1, 1'b0, 2'b11, 6'd9);
    send_beat(1'b0, 1'b1, 2'b00, 6'd9);
    drain();
    chk("restart_count", popped_q.size(), 1);
    if (popped_q.size() > 0) chk("restart_tag", popped_q[0], 8'hC9);
    chk("restart_err", err_count, 1);
    popped_q.delete();
    send_beat(1'b0, 1'b1, 2'b11, 6'd3);
    drain();
    chk("orphan_count", popped_q.size(), 1);
    if (popped_q.size() > 0) chk("orphan_tag", popped_q[0], 8'h03);
    chk("orphan_err", err_count, 2);
    for (int i = 0; i < 300; i++) send_beat(1'b0, 1'b1, 2'($urandom), 6'($urandom));
    drain();
    chk("err_saturate", err_count, 255);

    // Reset with 2 tags in the FIFO and 3 in the pipe
    popped_q.delete();
    tag_ready = 1'b0;
    send_beat(1'b1, 1'b1, 2'b01, 6'd40);
    send_beat(1'b1, 1'b1, 2'b10, 6'd41);
    idle(LAT);
    for (int i = 0; i < 3; i++) send_beat(1'b1, 1'b1, 2'b11, 6'(50 + i));
    reset = 1'b1;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tag_valid", tag_valid, 0);
    chk("rst_tag_data", tag_data, 0);
    chk("rst_err", err_count, 0);
    cycle();
    reset     = 1'b0;
    tag_ready = 1'b1;
    #3;
    chk("rst_release_in_ready", in_ready, 1);
    idle(LAT + 5);
    chk("rst_no_stale", popped_q.size(), 0);

    // Randomized traffic with random backpressure, protocol anomalies and resets
    rand_rdy = 1'b1;
    for (int pk = 0; pk < 200; pk++) begin
      int len;
      len = $urandom_range(1, 5);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        cycle();
        reset = 1'b0;
      end
      for (int b = 0; b < len; b++) begin
        bit sop;
        sop = (b == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
        send_beat(sop, b == len - 1, 2'($urandom), 6'($urandom));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_rdy  = 1'b0;
    tag_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
